// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, RV32I opcodes and funct7 values.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned OPC_W    = 7;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned F7_W     = 7;

    typedef enum logic [ALU_OP_W-1:0] {
        AddOp  = 4'd0,
        SubOp  = 4'd1,
        SllOp  = 4'd2,
        SltOp  = 4'd3,
        SltuOp = 4'd4,
        XorOp  = 4'd5,
        SrlOp  = 4'd6,
        SraOp  = 4'd7,
        OrOp   = 4'd8,
        AndOp  = 4'd9
    } alu_ops_t;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;

    localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

    // Map funct3 (plus the ir[30] alternate bit) onto an ALU operation.
    function automatic alu_ops_t f3_to_op(input logic [F3_W-1:0] f3, input logic alt);
        alu_ops_t op;
        op = AddOp;
        case (f3)
            3'b000:  op = alt ? SubOp : AddOp;
            3'b001:  op = SllOp;
            3'b010:  op = SltOp;
            3'b011:  op = SltuOp;
            3'b100:  op = XorOp;
            3'b101:  op = alt ? SraOp : SrlOp;
            3'b110:  op = OrOp;
            default: op = AndOp;
        endcase
        return op;
    endfunction

    function automatic logic is_shift_op(input alu_ops_t op);
        return (op == SllOp) || (op == SrlOp) || (op == SraOp);
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// RV32I immediate extraction: I-, S- and U-type immediates from the instruction word.
// Opcode bits ir[6:0] carry no immediate data, so only ir[31:7] is taken.
module rv32_imm_gen (
    input  logic [31:7] ir,
    output logic [31:0] i_imm_c,
    output logic [31:0] s_imm_c,
    output logic [31:0] u_imm_c
);

    assign i_imm_c = {{20{ir[31]}}, ir[31:20]};
    assign s_imm_c = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign u_imm_c = {ir[31:12], 12'b0};

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand/issue stage in front of the RV32I ALU with a valid/ready slice.
// Define ALU_OPERAND_ILLEGAL_EN to report unsupported encodings on illegal_o.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           ir_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output alu_ops_t              func_op_o,
    output logic                  illegal_o
);

`ifdef ALU_OPERAND_ILLEGAL_EN
    localparam bit ILLEGAL_EN = 1'b1;
`else
    localparam bit ILLEGAL_EN = 1'b0;
`endif

    localparam int unsigned SHAMT_W = 5;

    logic [OPC_W-1:0]      opcode;
    logic [F3_W-1:0]       funct3;
    logic [F7_W-1:0]       funct7;
    logic [DATA_WIDTH-1:0] i_imm;
    logic [DATA_WIDTH-1:0] s_imm;
    logic [DATA_WIDTH-1:0] u_imm;
    logic                  funct_ok;
    logic [DATA_WIDTH-1:0] dec_a;
    logic [DATA_WIDTH-1:0] dec_b;
    alu_ops_t              dec_op;
    logic                  dec_illegal;
    logic                  xfer;

    assign opcode = ir_i[6:0];
    assign funct3 = ir_i[14:12];
    assign funct7 = ir_i[31:25];

    rv32_imm_gen u_imm_gen (
        .ir      (ir_i[31:7]),
        .i_imm_c (i_imm),
        .s_imm_c (s_imm),
        .u_imm_c (u_imm)
    );

    // Combinational decode of the offered beat; illegal encodings fall back to rs1 + rs2.
    always_comb begin
        dec_a       = rs1_i;
        dec_b       = rs2_i;
        dec_op      = AddOp;
        dec_illegal = 1'b0;
        funct_ok    = 1'b1;
        case (opcode)
            OPC_OP: begin
                funct_ok = (funct7 == F7_BASE) ||
                           ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                if (funct_ok) dec_op = f3_to_op(funct3, ir_i[30]);
                else          dec_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                case (funct3)
                    3'b001:  funct_ok = (funct7 == F7_BASE);
                    3'b101:  funct_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    default: funct_ok = 1'b1;
                endcase
                if (funct_ok) begin
                    dec_b  = i_imm;
                    dec_op = f3_to_op(funct3, (funct3 == 3'b101) && ir_i[30]);
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_a = '0;
                dec_b = u_imm;
            end
            OPC_AUIPC: begin
                dec_a = pc_i;
                dec_b = u_imm;
            end
            OPC_LOAD:  dec_b = i_imm;
            OPC_STORE: dec_b = s_imm;
            default:   dec_illegal = 1'b1;
        endcase
        // The ALU shifts by all of b_i, so only the shift amount may survive.
        if (is_shift_op(dec_op)) dec_b = DATA_WIDTH'(dec_b[SHAMT_W-1:0]);
    end

    assign in_ready_o = !out_valid_o || out_ready_i;
    assign xfer       = in_valid_i && in_ready_o;

    // Single-entry output slice; reset wins over a same-cycle transfer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_valid_o <= 1'b0;
            a_o         <= '0;
            b_o         <= '0;
            func_op_o   <= AddOp;
            illegal_o   <= 1'b0;
        end else if (xfer) begin
            out_valid_o <= 1'b1;
            a_o         <= dec_a;
            b_o         <= dec_b;
            func_op_o   <= dec_op;
            illegal_o   <= ILLEGAL_EN && dec_illegal;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage; honours ALU_OPERAND_ILLEGAL_EN.
module tb_alu_operand_stage;
    import alu_pkg::*;

`ifdef ALU_OPERAND_ILLEGAL_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] ir_i;
    logic [31:0] pc_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] a_o;
    logic [31:0] b_o;
    alu_ops_t    func_op_o;
    logic        illegal_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    alu_operand_stage #(.DATA_WIDTH(32)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .ir_i        (ir_i),
        .pc_i        (pc_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .a_o         (a_o),
        .b_o         (b_o),
        .func_op_o   (func_op_o),
        .illegal_o   (illegal_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_beat(input logic [31:0] ir, input logic [31:0] pc,
                            input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid_i = 1'b1;
        ir_i       = ir;
        pc_i       = pc;
        rs1_i      = rs1;
        rs2_i      = rs2;
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic check_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input alu_ops_t op, input logic ill);
        check({tag, ".valid"}, 32'(out_valid_o), 32'd1);
        check({tag, ".a"},     a_o, a);
        check({tag, ".b"},     b_o, b);
        check({tag, ".op"},    32'(func_op_o), 32'(op));
        check({tag, ".ill"},   32'(illegal_o), 32'(ill));
    endtask

    // Send one beat with the sink ready and check it one cycle later.
    task automatic issue(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] a, input logic [31:0] b,
                         input alu_ops_t op, input logic ill);
        set_beat(ir, pc, rs1, rs2);
        out_ready_i = 1'b1;
        step();
        check_out(tag, a, b, op, ill);
    endtask

    initial begin
        reset_i     = 1'b1;
        out_ready_i = 1'b1;
        set_beat(32'h40208033, 32'h0, 32'd10, 32'd3);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst.valid", 32'(out_valid_o), 32'd0);
        check("rst.a",     a_o, 32'd0);
        check("rst.b",     b_o, 32'd0);
        check("rst.op",    32'(func_op_o), 32'(AddOp));
        check("rst.ill",   32'(illegal_o), 32'd0);
        check("rst.ready", 32'(in_ready_o), 32'd1);
        reset_i = 1'b0;

        issue("sub",   32'h40208033, 32'h0,   32'd10,        32'd3,
                       32'd10, 32'd3, SubOp, 1'b0);
        issue("srai",  32'h4041D093, 32'h0,   32'h80000000,  32'h12345678,
                       32'h80000000, 32'd4, SraOp, 1'b0);
        issue("sll",   32'h003110B3, 32'h0,   32'h0000_00AA, 32'hFFFFFFE5,
                       32'h0000_00AA, 32'd5, SllOp, 1'b0);
        issue("lui",   32'h12345037, 32'h40,  32'hDEADBEEF,  32'h1,
                       32'd0, 32'h12345000, AddOp, 1'b0);
        issue("auipc", 32'h00001017, 32'h100, 32'hDEADBEEF,  32'h1,
                       32'h100, 32'h1000, AddOp, 1'b0);
        issue("sw",    32'hFE20AE23, 32'h0,   32'h0000_2000, 32'h5,
                       32'h0000_2000, 32'hFFFFFFFC, AddOp, 1'b0);
        issue("lw",    32'hFFF12083, 32'h0,   32'h0000_3000, 32'h5,
                       32'h0000_3000, 32'hFFFFFFFF, AddOp, 1'b0);

        // Backpressure: lw is held while addi waits.
        set_beat(32'h00500093, 32'h0, 32'd7, 32'd99);
        out_ready_i = 1'b0;
        #1;
        check("bp.ready0", 32'(in_ready_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("bp.hold", 32'h0000_3000, 32'hFFFFFFFF, AddOp, 1'b0);
            check("bp.ready", 32'(in_ready_o), 32'd0);
        end
        out_ready_i = 1'b1;
        #1;
        check("bp.ready1", 32'(in_ready_o), 32'd1);
        step();
        check_out("bp.addi", 32'd7, 32'd5, AddOp, 1'b0);
        issue("xor",   32'h003140B3, 32'h0,   32'h0000_00F0, 32'h0000_00FF,
                       32'h0000_00F0, 32'h0000_00FF, XorOp, 1'b0);

        issue("illop",  32'h0000007F, 32'h0, 32'h11, 32'h22, 32'h11, 32'h22, AddOp, ILL_EXP);
        issue("mul",    32'h022080B3, 32'h0, 32'h33, 32'h44, 32'h33, 32'h44, AddOp, ILL_EXP);
        issue("slli_b", 32'h40209093, 32'h0, 32'h55, 32'h66, 32'h55, 32'h66, AddOp, ILL_EXP);
        issue("slti",   32'hFFF0A093, 32'h0, 32'h77, 32'h88, 32'h77, 32'hFFFFFFFF, SltOp, 1'b0);

        // Consume with nothing new offered drains the slice.
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step();
        check("drain.valid", 32'(out_valid_o), 32'd0);

        // Reset mid-operation beats a concurrent transfer.
        issue("pre_rst", 32'h40208033, 32'h0, 32'd9, 32'd2, 32'd9, 32'd2, SubOp, 1'b0);
        out_ready_i = 1'b0;
        reset_i     = 1'b1;
        set_beat(32'h003140B3, 32'h0, 32'd1, 32'd1);
        step();
        check("mrst.valid", 32'(out_valid_o), 32'd0);
        check("mrst.a",     a_o, 32'd0);
        check("mrst.b",     b_o, 32'd0);
        check("mrst.op",    32'(func_op_o), 32'(AddOp));
        reset_i    = 1'b0;
        in_valid_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
